// File: rtl/regfile_2r1w_clr.sv
// Register file: one write port, two registered read ports, self-clearing after reset/clr.
// Define REGFILE_BYPASS_EN for write-first forwarding; otherwise same-address reads are read-first.
module regfile_2r1w_clr #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_busy;
  logic              r_wr_drop;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata [2];

  logic [ADDR_W-1:0] w_raddr [2];
  logic [1:0]        w_fwd;
  logic              w_wr_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;

  assign w_raddr[0] = raddr_a;
  assign w_raddr[1] = raddr_b;

  // clr wins over a same-cycle write, so that write never reaches memory.
  assign w_wr_en    = (r_state == READY) && we && !clr;
  assign w_mem_we   = (r_state == CLEAR) || w_wr_en;
  assign w_mem_addr = (r_state == CLEAR) ? r_ptr : waddr;
  assign w_mem_data = (r_state == CLEAR) ? '0 : wdata;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_ptr     <= '0;
      r_busy    <= 1'b1;
      r_wr_drop <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_ptr     <= r_ptr + 1'b1;
          r_wr_drop <= we;
          if (r_ptr == {ADDR_W{1'b1}}) begin
            r_state <= READY;
            r_busy  <= 1'b0;
          end
        end
        READY: begin
          r_wr_drop <= we && clr;
          if (clr) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
    assign w_fwd[gi] = w_wr_en && (waddr == w_raddr[gi]);
`else
    assign w_fwd[gi] = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rdata[gi] <= '0;
      end else if (r_state == CLEAR) begin
        r_rdata[gi] <= '0;
      end else begin
        r_rdata[gi] <= w_fwd[gi] ? wdata : r_mem[w_raddr[gi]];
      end
    end
  end

  assign rdata_a = r_rdata[0];
  assign rdata_b = r_rdata[1];
  assign busy    = r_busy;
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Self-checking bench for regfile_2r1w_clr: directed scenarios plus a random phase
// compared against an array model of the store.
module tb_regfile_2r1w_clr;

  localparam int DEPTH = 256;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic [7:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] raddr_a = '0;
  logic [7:0] raddr_b = '0;
  logic       clr = 1'b0;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;
  logic       busy;
  logic       wr_drop;

  int n_err = 0;
  int n_chk = 0;
  logic [7:0] mem_m [DEPTH];

  regfile_2r1w_clr #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .clr(clr),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
  endtask

  initial begin
    int cnt;
    logic [7:0] exp_a, exp_b;

    model_clear();

    // Reset held
    repeat (3) cyc();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rdata_a", 32'(rdata_a), 32'd0);
    check("rst_rdata_b", 32'(rdata_b), 32'd0);
    check("rst_wr_drop", 32'(wr_drop), 32'd0);

    // Release; count busy cycles, injecting one dropped write mid-sweep
    rst = 1'b0;
    raddr_a = 8'h5A;
    raddr_b = 8'hC3;
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      if (cnt == 10) begin
        we = 1'b1; waddr = 8'h05; wdata = 8'hFF;
      end else if (cnt == 11) begin
        we = 1'b0;
        check("clear_wr_drop_pulse", 32'(wr_drop), 32'd1);
        check("clear_rdata_a_forced", 32'(rdata_a), 32'd0);
      end else if (cnt == 12) begin
        check("clear_wr_drop_single", 32'(wr_drop), 32'd0);
      end
      cnt++;
      cyc();
    end
    check("reset_busy_cycles", 32'(cnt), 32'(DEPTH));

    // Post-clear reads of boundary addresses on both ports
    for (int k = 0; k < 4; k++) begin
      logic [7:0] a;
      case (k)
        0: a = 8'h00;
        1: a = 8'h7F;
        2: a = 8'hFF;
        default: a = 8'h05;
      endcase
      raddr_a = a;
      raddr_b = a;
      cyc();
      check("post_clear_a", 32'(rdata_a), 32'(mem_m[a]));
      check("post_clear_b", 32'(rdata_b), 32'(mem_m[a]));
    end

    // Write then read on the next cycle
    we = 1'b1; waddr = 8'h10; wdata = 8'hA5;
    mem_m[8'h10] = 8'hA5;
    cyc();
    we = 1'b0; raddr_a = 8'h10; raddr_b = 8'h11;
    cyc();
    check("wr_rd_a", 32'(rdata_a), 32'hA5);
    check("wr_rd_b", 32'(rdata_b), 32'h00);

    // Same-address write/read collision
    we = 1'b1; waddr = 8'h20; wdata = 8'h11;
    cyc();
    wdata = 8'h3C; raddr_a = 8'h20;
    cyc();
    we = 1'b0;
    check("collide_first", 32'(rdata_a), BYP ? 32'h3C : 32'h11);
    cyc();
    check("collide_second", 32'(rdata_a), 32'h3C);

    // clr together with a write: write dropped, full sweep
    we = 1'b1; waddr = 8'h40; wdata = 8'h77;
    cyc();
    raddr_a = 8'h40;
    we = 1'b1; waddr = 8'h41; wdata = 8'h99; clr = 1'b1;
    cyc();
    we = 1'b0; clr = 1'b0;
    check("clr_wr_drop", 32'(wr_drop), 32'd1);
    model_clear();
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      if (cnt == 1) check("clr_wr_drop_single", 32'(wr_drop), 32'd0);
      if (cnt == 5) clr = 1'b1;
      if (cnt == 6) clr = 1'b0;
      cnt++;
      cyc();
    end
    check("clr_busy_cycles", 32'(cnt), 32'(DEPTH));
    raddr_a = 8'h40; raddr_b = 8'h41;
    cyc();
    check("clr_0x40", 32'(rdata_a), 32'h00);
    check("clr_0x41", 32'(rdata_b), 32'h00);

    // Asynchronous reset while READY with non-zero read data
    we = 1'b1; waddr = 8'h30; wdata = 8'h5A;
    cyc();
    we = 1'b0; raddr_a = 8'h30;
    cyc();
    check("ready_rd_0x30", 32'(rdata_a), 32'h5A);
    rst = 1'b1;
    #1;
    check("async_rst_rdata_a", 32'(rdata_a), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd1);
    cyc();
    rst = 1'b0;
    model_clear();
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      cyc();
    end
    check("rst_ready_busy_cycles", 32'(cnt), 32'(DEPTH));

    // Reset mid-clear at ptr=100 with a pending wr_drop
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (99) cyc();
    we = 1'b1;
    cyc();
    we = 1'b0;
    check("midclear_wr_drop", 32'(wr_drop), 32'd1);
    rst = 1'b1;
    #1;
    check("midclear_rst_wr_drop", 32'(wr_drop), 32'd0);
    check("midclear_rst_rdata_b", 32'(rdata_b), 32'd0);
    check("midclear_rst_busy", 32'(busy), 32'd1);
    cyc();
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      cyc();
    end
    check("midclear_busy_cycles", 32'(cnt), 32'(DEPTH));
    raddr_a = 8'h30; raddr_b = 8'hFF;
    cyc();
    check("midclear_0x30", 32'(rdata_a), 32'h00);
    check("midclear_0xFF", 32'(rdata_b), 32'h00);

    // Random traffic against the array model
    for (int i = 0; i < 2000; i++) begin
      bit narrow;
      narrow  = 1'($urandom_range(0, 1));
      we      = 1'($urandom_range(0, 1));
      wdata   = 8'($urandom);
      waddr   = narrow ? 8'($urandom_range(0, 7)) : 8'($urandom);
      raddr_a = narrow ? 8'($urandom_range(0, 7)) : 8'($urandom);
      raddr_b = narrow ? 8'($urandom_range(0, 7)) : 8'($urandom);
      exp_a = (BYP && we && waddr == raddr_a) ? wdata : mem_m[raddr_a];
      exp_b = (BYP && we && waddr == raddr_b) ? wdata : mem_m[raddr_b];
      if (we) mem_m[waddr] = wdata;
      cyc();
      check("rand_rdata_a", 32'(rdata_a), 32'(exp_a));
      check("rand_rdata_b", 32'(rdata_b), 32'(exp_b));
      check("rand_wr_drop", 32'(wr_drop), 32'd0);
    end
    we = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_clr.md
# regfile_2r1w_clr

Parametrised register file with one write port and two independent synchronous read ports. A built-in clear sequencer zeroes every location after reset or on request. It replaces the single-port 256x8 register store in the accumulator datapath, so operand fetch and result write-back can proceed in the same cycle.

## Interface
Parameters:
- `DATA_W`, 8: word width in bits.
- `ADDR_W`, 8: address width; depth `DEPTH = 2**ADDR_W`.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `we` input 1: write enable.
- `waddr` input ADDR_W: write address.
- `wdata` input DATA_W: write data.
- `raddr_a` input ADDR_W: read port A address.
- `raddr_b` input ADDR_W: read port B address.
- `clr` input 1: clear request; single-cycle pulse or level.
- `rdata_a` output DATA_W: registered read data, port A.
- `rdata_b` output DATA_W: registered read data, port B.
- `busy` output 1: high while the clear sequencer runs.
- `wr_drop` output 1: one-cycle pulse when a write is discarded.

## Operation
- Storage is `DEPTH` words of `DATA_W` bits. Read ports are always enabled.
- FSM has two states, CLEAR and READY.
- **Reset** (`rst`=1): state=CLEAR, clear pointer `ptr`=0, `busy`=1, `rdata_a`=`rdata_b`=0, `wr_drop`=0. Memory contents are not reset directly; the sequencer zeroes them.
- **CLEAR** behaviour, each cycle:
  - Writes 0 to `mem[ptr]` and increments `ptr`.
  - When the cycle writing `ptr==DEPTH-1` completes, `ptr` wraps to 0 and the state goes to READY.
  - `rdata_a`/`rdata_b` are forced to 0.
  - `we` is ignored; each cycle with `we`=1 produces `wr_drop`=1 on the next edge.
  - `clr` is ignored; the sweep is not restarted.
- **READY** behaviour:
  - With `we`=1: `mem[waddr] <= wdata`.
  - Each read port registers `mem[raddr_x]`.
  - With `clr`=1: the state goes to CLEAR at the next edge with `ptr`=0. A `we` in the same cycle is dropped and `wr_drop` pulses, because `clr` has priority.
- **Same-address collisions:**
  - A read address equal to `waddr` with `we`=1 follows the bypass rule in Configuration.
  - Both read ports may use the same address; both return the same value.
- Addresses are full-range; there is no out-of-range case.

## Timing
- Read latency is 1 cycle: the address is sampled at edge N and data is valid after edge N and held until edge N+1.
- A write at edge N is visible to a read address sampled at edge N+1, i.e. data appears after N+1.
- Clear duration:
  - `busy` is high for exactly `DEPTH` cycles after the first rising edge following `rst` deassertion.
  - After a `clr` sampled at edge N, `busy` rises after N and stays high through edge N+DEPTH.
- `busy` is registered and is 1 exactly while the state is CLEAR.
- `wr_drop` is registered, one cycle per dropped write.
- Asserting `rst` mid-clear or mid-operation immediately returns the block to the reset values; the sweep restarts from `ptr`=0.

## Configuration
- Macro `REGFILE_BYPASS_EN` controls write-to-read forwarding.
- **Defined:** in READY, a read port whose address equals `waddr` while `we`=1 registers `wdata` (write-first).
- **Undefined:** that port registers the old `mem[raddr]` (read-first), matching the legacy register store.
- No other behaviour changes. In CLEAR, outputs are forced to 0 regardless of the macro.

## Test plan
- Reset release, DATA_W=8, ADDR_W=8 -> `busy`=1 for exactly 256 cycles; then reading addresses 0x00, 0x7F and 0xFF on both ports returns 0x00.
- In READY, write 0xA5 to 0x10, then on the next cycle set `raddr_a`=0x10 and `raddr_b`=0x11 -> one cycle later `rdata_a`=0xA5 and `rdata_b`=0x00.
- Address 0x20 holds 0x11; write 0x3C to 0x20 while `raddr_a`=0x20 in the same cycle:
  - With `REGFILE_BYPASS_EN` -> `rdata_a`=0x3C.
  - Without it -> `rdata_a`=0x11, and a second read returns 0x3C.
- `we`=1, `waddr`=0x05, `wdata`=0xFF during CLEAR -> `wr_drop` pulses once; after `busy` falls, address 0x05 reads 0x00.
- With 0x77 stored at 0x40:
  - Pulse `clr` together with a write of 0x99 to 0x41 -> `wr_drop`=1, `busy` high for 256 cycles.
  - Afterwards, 0x40 and 0x41 both read 0x00.
- Assert `rst` at `ptr`=100 during CLEAR, then release -> all outputs return to 0 and `busy` stays high a full 256 cycles from release.
